jtkiwi_pcm_mch: RTL and testbench
=================================

# jtkiwi_pcm_mch

Multi-channel table-driven PCM sample player for the Kiwi-family sound subsystem. It extends the single-channel Kageki scheme to CH independent voices that share one 8-bit ROM port. Each voice is started by a rising edge on its trigger, looks up a 16-bit start address in a pointer table, and then streams unsigned 8-bit samples until a zero byte. Per-voice outputs are raw unsigned bytes that feed DC removal and the mixer; optional looping and forced stop are supported.

## Interface
Parameters:
- CH, 2, number of voices (1–8)
- AW, 16, PCM ROM address width
- IDW, 6, sample index width per voice
- TBL_BASE, 16'h90, pointer-table base address (AW bits)
- DIV, 3, sample strobes per playback tick (1–15)

Ports:
- clk  in  1  system clock
- comb_rstn  in  1  reset, asynchronous, active-low
- sample  in  1  FM-chip sample strobe (level; rising edge counted)
- trig  in  CH  per-voice start (rising edge)
- idx  in  CH*IDW  per-voice sample index; voice c uses idx[c*IDW +: IDW]
- loop  in  CH  per-voice loop enable
- stop  in  CH  per-voice forced stop (level)
- rom_addr  out  AW  ROM byte address
- rom_cs  out  1  ROM request
- rom_data  in  8  ROM byte
- rom_ok  in  1  rom_data valid for the current rom_addr
- pcm  out  CH*8  per-voice last sample, unsigned
- busy  out  CH  voice not IDLE
- done  out  CH  one-cycle pulse when a voice ends naturally
- ovr  out  1  sticky overrun flag

## Operation
- Divider: sample_l register; a rising edge is sample && !sample_l. A 4-bit counter increments on each edge. On the DIV-th edge it clears and tick pulses for one cycle, registered one clk after the edge-detect cycle.
- Voice states: IDLE, LSB, MSB, PLAY. Each voice has addr (AW bits), lsb, start (AW bits), pend and pcm registers.
- On tick, every non-IDLE voice sets pend. If pend is already set, ovr is set and pend stays set (no queueing).
- Arbiter FSM: A_IDLE, A_REQ, A_WAIT.
  - A_IDLE: if any pend is set, grant the lowest index, load rom_addr with that voice's addr, and go to A_REQ.
  - A_REQ: rom_cs=1 for one settle cycle, then go to A_WAIT.
  - A_WAIT: rom_cs=1 until rom_ok is sampled high. Then apply the byte to the granted voice, clear its pend, drop rom_cs and return to A_IDLE.
  - rom_addr is stable while rom_cs is high.
- Applying a byte:
  - LSB: lsb<=byte, addr<=addr+1, go to MSB.
  - MSB: addr<=start<={byte,lsb}, go to PLAY.
  - PLAY: pcm<=byte, addr<=addr+1 (wraps).
    - If byte==0 or addr was all-ones: with loop=1, addr<=start and stay in PLAY; otherwise go to IDLE and pulse done.
- Trigger: on a rising edge of trig[c], state<=LSB, addr<=TBL_BASE+{idx_c,1'b0} (AW-bit add, wraps), pend<=0, busy=1. This applies from any state.
  - If voice c is granted with a fetch in flight, that fetch completes on the bus but its byte is discarded.
  - The first table fetch happens on the next tick.
- stop[c] high: state<=IDLE, pend<=0, pcm<=0, no done pulse. An in-flight byte for that voice is discarded. stop has priority over trig in the same cycle.
- Trigger and tick in the same cycle: the trigger wins and pend stays 0 for that voice.

## Timing
- Reset values: rom_addr=0, rom_cs=0, pcm=0, busy=0, done=0, ovr=0, all voices IDLE, divider=0, arbiter A_IDLE. ovr is cleared only by reset.
- Minimum fetch: 3 clk (A_IDLE, A_REQ, A_WAIT with rom_ok). Each extra cycle of rom_ok low adds one clk.
- pcm updates on the clk edge after rom_ok is sampled in A_WAIT. done pulses on that same edge.
- Latency from trigger to first audible sample: 3 ticks (LSB, MSB, first PLAY byte).
- busy drops together with the done pulse.
- All voices are served within one tick period provided CH*3 clk ≤ DIV sample periods and rom_ok is timely.

## Test plan
- CH=1, DIV=1, TBL_BASE=0x90, idx=5. ROM[0x9a]=0x00, ROM[0x9b]=0x40, ROM[0x4000..2]=0x12,0x34,0x00.
  - Required fetch order: 0x9a, 0x9b, 0x4000, 0x4001, 0x4002.
  - pcm goes 0x12, 0x34, 0x00 on successive ticks; done pulses once; busy falls.
- DIV=3, 9 sample edges with sample held high several clk each -> exactly 3 tick pulses, at the 3rd, 6th and 9th edges.
- CH=2, both trig in the same cycle with different idx -> voice 0 fetch completes before voice 1 is granted; both pend cleared before the next tick; ovr=0.
- Retrigger during PLAY while that voice's fetch is in flight (rom_ok delayed) -> in-flight byte not applied to pcm; next fetch address is the new table entry.
- loop=1, data 0x55,0x00 -> pcm 0x55, 0x00, 0x55, 0x00… with no done.
  - Then stop=1 -> busy=0, pcm=0, no done.
  - Separately: start address 0xFFFF with nonzero byte, loop=0 -> IDLE with done.
- rom_ok held low longer than one tick period with a voice playing -> ovr=1 and stays 1 after rom_ok returns; comb_rstn low -> ovr=0 and all outputs at reset values.

Source files
------------

// File: rtl/jtkiwi_pcm_mch.sv
// jtkiwi_pcm_mch: multi-voice table-driven PCM player sharing one 8-bit ROM port
module jtkiwi_pcm_mch #(
   parameter int CH = 2,
   parameter int AW = 16,
   parameter int IDW = 6,
   parameter logic [AW-1:0] TBL_BASE = 'h90,
   parameter int DIV = 3
) (
   input  logic              clk,
   input  logic              comb_rstn,
   input  logic              sample,
   input  logic [CH-1:0]     trig,
   input  logic [CH*IDW-1:0] idx,
   input  logic [CH-1:0]     loop,
   input  logic [CH-1:0]     stop,
   output logic [AW-1:0]     rom_addr,
   output logic              rom_cs,
   input  logic [7:0]        rom_data,
   input  logic              rom_ok,
   output logic [CH*8-1:0]   pcm,
   output logic [CH-1:0]     busy,
   output logic [CH-1:0]     done,
   output logic              ovr
);
   localparam int GW = CH > 1 ? $clog2(CH) : 1;
   typedef enum logic [1:0] {IDLE, LSB, MSB, PLAY} vst_e;
   typedef enum logic [1:0] {A_IDLE, A_REQ, A_WAIT} ast_e;
   vst_e          st_q[CH], st_d[CH];
   logic [AW-1:0] addr_q[CH], addr_d[CH], start_q[CH], start_d[CH];
   logic [7:0]    lsb_q[CH], lsb_d[CH], pcm_q[CH], pcm_d[CH];
   logic [CH-1:0] pend_q, pend_d, done_q, done_d, trig_l_q, trg;
   ast_e          arb_q, arb_d;
   logic [GW-1:0] gnt_q, gnt_d, sel;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          any, fin, se;
   logic          kill_q, kill_d, rom_cs_q, rom_cs_d, ovr_q, ovr_d;
   logic          sample_l_q, tick_q, tick_d;

   assign se     = sample & ~sample_l_q;
   assign trg    = trig & ~trig_l_q;
   assign cnt_d  = se ? (cnt_q == 4'(DIV-1) ? 4'd0 : cnt_q + 4'd1) : cnt_q;
   assign tick_d = se && cnt_q == 4'(DIV-1);

   // kill marks an in-flight fetch whose voice was retriggered or stopped
   always_comb begin
      sel = '0;
      any = 1'b0;
      for (int c = CH-1; c >= 0; c--) if (pend_q[c]) begin
         sel = GW'(c);
         any = 1'b1;
      end
      arb_d      = arb_q;
      gnt_d      = gnt_q;
      rom_addr_d = rom_addr_q;
      rom_cs_d   = rom_cs_q;
      kill_d     = kill_q | trg[gnt_q] | stop[gnt_q];
      fin        = 1'b0;
      case (arb_q)
         A_IDLE: if (any) begin
            arb_d      = A_REQ;
            gnt_d      = sel;
            rom_addr_d = addr_q[sel];
            rom_cs_d   = 1'b1;
            kill_d     = trg[sel] | stop[sel];
         end
         A_REQ: arb_d = A_WAIT;
         default: if (rom_ok) begin
            arb_d    = A_IDLE;
            rom_cs_d = 1'b0;
            fin      = 1'b1;
         end
      endcase
   end

   always_comb begin
      ovr_d = ovr_q;
      for (int c = 0; c < CH; c++) begin
         st_d[c]    = st_q[c];
         addr_d[c]  = addr_q[c];
         start_d[c] = start_q[c];
         lsb_d[c]   = lsb_q[c];
         pcm_d[c]   = pcm_q[c];
         pend_d[c]  = pend_q[c];
         done_d[c]  = 1'b0;
         if (fin && !kill_d && gnt_q == GW'(c)) begin
            pend_d[c] = 1'b0;
            case (st_q[c])
               LSB: begin
                  lsb_d[c]  = rom_data;
                  addr_d[c] = addr_q[c] + 1'b1;
                  st_d[c]   = MSB;
               end
               MSB: begin
                  addr_d[c]  = AW'({rom_data, lsb_q[c]});
                  start_d[c] = AW'({rom_data, lsb_q[c]});
                  st_d[c]    = PLAY;
               end
               PLAY: begin
                  pcm_d[c]  = rom_data;
                  addr_d[c] = addr_q[c] + 1'b1;
                  if (rom_data == 8'd0 || addr_q[c] == '1) begin
                     addr_d[c] = loop[c] ? start_q[c] : addr_d[c];
                     st_d[c]   = loop[c] ? PLAY : IDLE;
                     done_d[c] = !loop[c];
                  end
               end
               default: ;
            endcase
         end
         if (stop[c]) begin
            st_d[c]   = IDLE;
            pend_d[c] = 1'b0;
            pcm_d[c]  = 8'd0;
         end else if (trg[c]) begin
            st_d[c]   = LSB;
            addr_d[c] = TBL_BASE + AW'({idx[c*IDW +: IDW], 1'b0});
            pend_d[c] = 1'b0;
         end else if (tick_q && st_d[c] != IDLE) begin
            ovr_d     = ovr_d | pend_d[c];
            pend_d[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge comb_rstn)
      if (!comb_rstn) begin
         st_q       <= '{default: IDLE};
         addr_q     <= '{default: '0};
         start_q    <= '{default: '0};
         lsb_q      <= '{default: '0};
         pcm_q      <= '{default: '0};
         pend_q     <= '0;
         done_q     <= '0;
         trig_l_q   <= '0;
         arb_q      <= A_IDLE;
         gnt_q      <= '0;
         rom_addr_q <= '0;
         rom_cs_q   <= 1'b0;
         kill_q     <= 1'b0;
         ovr_q      <= 1'b0;
         cnt_q      <= '0;
         sample_l_q <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         st_q       <= st_d;
         addr_q     <= addr_d;
         start_q    <= start_d;
         lsb_q      <= lsb_d;
         pcm_q      <= pcm_d;
         pend_q     <= pend_d;
         done_q     <= done_d;
         trig_l_q   <= trig;
         arb_q      <= arb_d;
         gnt_q      <= gnt_d;
         rom_addr_q <= rom_addr_d;
         rom_cs_q   <= rom_cs_d;
         kill_q     <= kill_d;
         ovr_q      <= ovr_d;
         cnt_q      <= cnt_d;
         sample_l_q <= sample;
         tick_q     <= tick_d;
      end

   for (genvar i = 0; i < CH; i++) begin : g_out
      assign pcm[i*8 +: 8] = pcm_q[i];
      assign busy[i]       = st_q[i] != IDLE;
   end
   assign done     = done_q;
   assign rom_addr = rom_addr_q;
   assign rom_cs   = rom_cs_q;
   assign ovr      = ovr_q;
endmodule

// File: tb/tb_jtkiwi_pcm_mch.sv
// tb_jtkiwi_pcm_mch: directed checks of the multi-voice PCM player
module tb_jtkiwi_pcm_mch;
   logic        clk = 0, comb_rstn = 0, sample = 0, rom_ok_en = 1;
   logic [1:0]  trig = 0, loop = 0, stop = 0, busy, done;
   logic [5:0]  idx0 = 0, idx1 = 0;
   logic [15:0] rom_addr, pcm;
   logic [7:0]  rom_data;
   logic        rom_cs, rom_ok, ovr, cs_l = 0;
   logic [7:0]  mem [0:65535];
   logic [15:0] fetch_log [$];
   int          n_chk = 0, n_err = 0, n_tick = 0, dn0 = 0, dn1 = 0, d0;

   jtkiwi_pcm_mch #(.CH(2), .AW(16), .IDW(6), .TBL_BASE(16'h90), .DIV(3)) u_dut (
      .clk(clk), .comb_rstn(comb_rstn), .sample(sample), .trig(trig), .idx({idx1, idx0}),
      .loop(loop), .stop(stop), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
      .rom_ok(rom_ok), .pcm(pcm), .busy(busy), .done(done), .ovr(ovr)
   );

   always #5 clk = ~clk;
   assign rom_data = mem[rom_addr];
   assign rom_ok   = rom_cs & rom_ok_en;

   always @(negedge clk) begin
      if (rom_cs && !cs_l) fetch_log.push_back(rom_addr);
      cs_l = rom_cs;
      if (done[0]) dn0++;
      if (done[1]) dn1++;
      if (u_dut.tick_q) n_tick++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse;
      sample = 1;
      clks(3);
      sample = 0;
      clks(2);
   endtask

   task automatic tick;
      repeat (3) pulse();
      clks(6);
   endtask

   task automatic fire(input logic [1:0] m);
      trig = m;
      clks(1);
      trig = 0;
   endtask

   task automatic halt(input logic [1:0] m);
      stop = m;
      clks(1);
      stop = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h9a] = 8'h00; mem[16'h9b] = 8'h40;
      mem[16'h9c] = 8'h00; mem[16'h9d] = 8'h50;
      mem[16'h9e] = 8'h00; mem[16'h9f] = 8'h60;
      mem[16'ha0] = 8'hff; mem[16'ha1] = 8'hff;
      mem[16'h4000] = 8'h12; mem[16'h4001] = 8'h34; mem[16'h4002] = 8'h00;
      mem[16'h5000] = 8'h77; mem[16'h5001] = 8'h00;
      mem[16'h6000] = 8'h55; mem[16'h6001] = 8'h00;
      mem[16'hffff] = 8'h99;
      clks(3);
      check("rst_busy", busy, 0);
      check("rst_pcm", pcm, 0);
      check("rst_cs", rom_cs, 0);
      comb_rstn = 1;
      clks(2);
      // divider: ticks only on every third sample edge
      for (int e = 1; e <= 9; e++) begin
         pulse();
         check($sformatf("div_e%0d", e), n_tick, e / 3);
      end
      // single voice walk through table and data
      idx0 = 5;
      fetch_log.delete();
      fire(2'b01);
      check("t1_busy", busy, 2'b01);
      tick(); tick();
      check("t1_msb_pcm", pcm[7:0], 8'h00);
      tick(); check("t1_pcm0", pcm[7:0], 8'h12);
      tick(); check("t1_pcm1", pcm[7:0], 8'h34);
      tick(); check("t1_pcm2", pcm[7:0], 8'h00);
      check("t1_busy_end", busy, 0);
      check("t1_done", dn0, 1);
      begin
         logic [15:0] exp_a [5] = '{16'h9a, 16'h9b, 16'h4000, 16'h4001, 16'h4002};
         check("t1_nfetch", fetch_log.size(), 5);
         for (int i = 0; i < 5; i++)
            check($sformatf("t1_fetch%0d", i), i < fetch_log.size() ? fetch_log[i] : 16'hdead, exp_a[i]);
      end
      // two voices triggered together
      idx0 = 5; idx1 = 6;
      fetch_log.delete();
      fire(2'b11);
      tick();
      check("t3_nfetch", fetch_log.size(), 2);
      check("t3_first", fetch_log.size() > 0 ? fetch_log[0] : 16'hdead, 16'h9a);
      check("t3_second", fetch_log.size() > 1 ? fetch_log[1] : 16'hdead, 16'h9c);
      check("t3_pend", u_dut.pend_q, 0);
      tick(); tick();
      check("t3_pcm_a", pcm, 16'h7712);
      tick(); check("t3_pcm_b", pcm, 16'h0034);
      check("t3_busy", busy, 2'b01);
      tick(); check("t3_busy_end", busy, 0);
      check("t3_done0", dn0, 2);
      check("t3_done1", dn1, 1);
      check("t3_ovr", ovr, 0);
      // retrigger with a stalled fetch in flight
      idx0 = 5;
      fire(2'b01);
      tick(); tick(); tick();
      check("t4_pcm0", pcm[7:0], 8'h12);
      rom_ok_en = 0;
      tick();
      idx0 = 6;
      fire(2'b01);
      clks(2);
      rom_ok_en = 1;
      clks(4);
      check("t4_discard", pcm[7:0], 8'h12);
      fetch_log.delete();
      tick();
      check("t4_newaddr", fetch_log.size() > 0 ? fetch_log[0] : 16'hdead, 16'h9c);
      halt(2'b01);
      // looping voice then forced stop
      idx0 = 7; loop = 2'b01;
      fire(2'b01);
      tick(); tick();
      d0 = dn0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t5_loop%0d", i), pcm[7:0], i[0] ? 8'h00 : 8'h55);
      end
      check("t5_busy", busy[0], 1);
      halt(2'b01);
      clks(1);
      check("t5_stop_busy", busy[0], 0);
      check("t5_stop_pcm", pcm[7:0], 8'h00);
      check("t5_nodone", dn0, d0);
      loop = 0;
      // start address at the top of the ROM ends after one byte
      idx0 = 8;
      fire(2'b01);
      tick(); tick(); tick();
      check("t5b_pcm", pcm[7:0], 8'h99);
      check("t5b_busy", busy[0], 0);
      check("t5b_done", dn0, d0 + 1);
      // overrun from a stalled ROM, then reset
      idx0 = 5;
      rom_ok_en = 0;
      fire(2'b01);
      tick();
      check("t6_ovr0", ovr, 0);
      tick();
      check("t6_ovr1", ovr, 1);
      rom_ok_en = 1;
      clks(5);
      check("t6_sticky", ovr, 1);
      comb_rstn = 0;
      #1;
      check("t6_rst_ovr", ovr, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_pcm", pcm, 0);
      check("t6_rst_cs", rom_cs, 0);
      check("t6_rst_addr", rom_addr, 0);
      check("t6_rst_done", done, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
